// File: rtl/lfsr_timer_pkg.sv
// Shared state encoding, mode values and legacy LFSR constants for the
// programmable LFSR tick timer.
package lfsr_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

   // Legacy 16-bit 1 ms tick generator configuration.
   localparam logic [15:0] DEFAULT_TAPS = 16'h002D;
   localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;

endpackage

// File: rtl/lfsr_galois_step.sv
// One Galois LFSR step: shift left, and when the MSB falls out, XOR the tap
// mask in (bit 0 always takes the MSB).
module lfsr_galois_step
   import lfsr_timer_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
   input  logic [WIDTH-1:0] lfsr,
   output logic [WIDTH-1:0] lfsr_next
);

   localparam logic [WIDTH-1:0] FEEDBACK = TAPS | WIDTH'(1);

   assign lfsr_next = {lfsr[WIDTH-2:0], 1'b0} ^ (FEEDBACK & {WIDTH{lfsr[WIDTH-1]}});

endmodule

// File: rtl/lfsr_tick_timer.sv
// Programmable LFSR tick generator with periodic / one-shot modes.
// Optional tick counter output enabled by defining LFSR_TICK_COUNT_EN.
module lfsr_tick_timer
   import lfsr_timer_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
   parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
`ifdef LFSR_TICK_COUNT_EN
   ,
   parameter int               CNT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [WIDTH-1:0] term_val,
   output logic             tick,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
`ifdef LFSR_TICK_COUNT_EN
   ,
   output logic [CNT_W-1:0] tick_cnt
`endif
);

   state_t           state, state_d;
   logic [WIDTH-1:0] lfsr, lfsr_d, lfsr_step;
   logic [WIDTH-1:0] term_q, term_d;
   logic             mode_q, mode_d;
   logic             tick_d, cfg_err_d;
   logic             start_req, start_ok, term_hit;

   lfsr_galois_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_step (
      .lfsr      (lfsr),
      .lfsr_next (lfsr_step)
   );

   // Stop outranks start; start is only heard outside RUN.
   assign start_req = start && !stop && (state != RUN);
   assign start_ok  = start_req && (term_val != '0);
   assign term_hit  = (state == RUN) && enable && (lfsr == term_q);

   always_comb begin
      // NOTE: default every comb output first so no path leaves it unassigned (no latch).
      state_d = state;
      if (stop) begin
         state_d = IDLE;
      end else if (start_ok) begin
         state_d = RUN;
      end else if (term_hit && (mode_q == MODE_ONESHOT)) begin
         state_d = DONE;
      end
   end

   always_comb begin
      lfsr_d    = lfsr;
      term_d    = term_q;
      mode_d    = mode_q;
      tick_d    = term_hit && !stop;
      cfg_err_d = start_req && (term_val == '0);
      if (stop || (state != RUN)) begin
         lfsr_d = SEED;
      end else if (enable) begin
         lfsr_d = term_hit ? SEED : lfsr_step;
      end
      if (start_ok) begin
         term_d = term_val;
         mode_d = mode;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         lfsr    <= SEED;
         term_q  <= '0;
         mode_q  <= MODE_PERIODIC;
         tick    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together.
         state   <= state_d;
         lfsr    <= lfsr_d;
         term_q  <= term_d;
         mode_q  <= mode_d;
         tick    <= tick_d;
         busy    <= (state_d == RUN);
         done    <= (state_d == DONE);
         cfg_err <= cfg_err_d;
      end
   end

`ifdef LFSR_TICK_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (stop || start_ok) begin
         tick_cnt <= '0;
      end else if (tick_d) begin
         tick_cnt <= tick_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_lfsr_tick_timer.sv
// Scoreboard bench for lfsr_tick_timer; cycle model built on lfsr_galois_step.
// Define LFSR_TICK_COUNT_EN to also exercise the tick counter (CNT_W=2).
module tb_lfsr_tick_timer;
   import lfsr_timer_pkg::*;

   localparam logic [15:0] SEED = DEFAULT_SEED;

   logic        clk = 1'b0;
   logic        rst, enable, start, stop, mode;
   logic [15:0] term_val;
   logic        tick, busy, done, cfg_err;
`ifdef LFSR_TICK_COUNT_EN
   logic [1:0]  tick_cnt;
`endif

   always #5 clk = ~clk;

   lfsr_tick_timer #(
      .WIDTH (16),
      .TAPS  (DEFAULT_TAPS),
      .SEED  (SEED)
`ifdef LFSR_TICK_COUNT_EN
      ,
      .CNT_W (2)
`endif
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .start    (start),
      .stop     (stop),
      .mode     (mode),
      .term_val (term_val),
      .tick     (tick),
      .busy     (busy),
      .done     (done),
      .cfg_err  (cfg_err)
`ifdef LFSR_TICK_COUNT_EN
      ,
      .tick_cnt (tick_cnt)
`endif
   );

   // Reference model state and its own LFSR step instance.
   state_t      m_state;
   logic [15:0] m_lfsr, m_term, m_next;
   logic        m_mode;
`ifdef LFSR_TICK_COUNT_EN
   logic [1:0]  m_cnt;
`endif

   lfsr_galois_step #(.WIDTH(16), .TAPS(DEFAULT_TAPS)) u_model_step (
      .lfsr (m_lfsr), .lfsr_next (m_next));

   logic [15:0] p_in, p_out;
   lfsr_galois_step #(.WIDTH(16), .TAPS(DEFAULT_TAPS)) u_probe_step (
      .lfsr (p_in), .lfsr_next (p_out));

   typedef struct {
      logic tick;
      logic busy;
      logic done;
      logic cfg_err;
`ifdef LFSR_TICK_COUNT_EN
      logic [1:0] cnt;
`endif
   } exp_t;

   exp_t  sb[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   string cur_test;

   task automatic model_reset();
      m_state = IDLE;
      m_lfsr  = SEED;
      m_term  = '0;
      m_mode  = 1'b0;
`ifdef LFSR_TICK_COUNT_EN
      m_cnt   = '0;
`endif
      sb.delete();
   endtask

   // Drive one cycle of stimulus, predict the registered outputs, compare after the edge.
   task automatic cycle(input logic en, input logic st, input logic sp,
                        input logic md, input logic [15:0] tv);
      exp_t e, got;
      enable = en; start = st; stop = sp; mode = md; term_val = tv;
      #1;
      e.tick    = 1'b0;
      e.cfg_err = 1'b0;
      if (sp) begin
         m_state = IDLE;
         m_lfsr  = SEED;
`ifdef LFSR_TICK_COUNT_EN
         m_cnt   = '0;
`endif
      end else if (m_state == RUN) begin
         if (en) begin
            if (m_lfsr == m_term) begin
               e.tick = 1'b1;
               m_lfsr = SEED;
`ifdef LFSR_TICK_COUNT_EN
               m_cnt  = m_cnt + 2'd1;
`endif
               if (m_mode == MODE_ONESHOT) m_state = DONE;
            end else begin
               m_lfsr = m_next;
            end
         end
      end else if (st) begin
         if (tv != 16'h0000) begin
            m_term  = tv;
            m_mode  = md;
            m_state = RUN;
`ifdef LFSR_TICK_COUNT_EN
            m_cnt   = '0;
`endif
         end else begin
            e.cfg_err = 1'b1;
         end
      end
      e.busy = (m_state == RUN);
      e.done = (m_state == DONE);
`ifdef LFSR_TICK_COUNT_EN
      e.cnt  = m_cnt;
`endif
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      n_tests++;
      if ({tick, busy, done, cfg_err} !== {got.tick, got.busy, got.done, got.cfg_err}) begin
         n_fail++;
         $display("FAIL %s outputs: got tick=%b busy=%b done=%b cfg_err=%b, want %b %b %b %b",
                  cur_test, tick, busy, done, cfg_err, got.tick, got.busy, got.done, got.cfg_err);
      end
`ifdef LFSR_TICK_COUNT_EN
      n_tests++;
      if (tick_cnt !== got.cnt) begin
         n_fail++;
         $display("FAIL %s tick_cnt: got %0d, want %0d", cur_test, tick_cnt, got.cnt);
      end
`endif
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic test_reset();
      cur_test = "reset";
      rst = 1'b1; enable = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; term_val = '0;
      @(posedge clk); @(posedge clk); #1;
      n_tests++;
      if ({tick, busy, done, cfg_err} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset outputs: got %b%b%b%b, want 0000", tick, busy, done, cfg_err);
      end
      rst = 1'b0;
      model_reset();
      @(posedge clk); #1;
   endtask

   task automatic test_periodic();
      int ticks = 0;
      cur_test = "periodic";
      cycle(1, 1, 0, MODE_PERIODIC, 16'hFFD3);
      for (int i = 0; i < 8; i++) begin
         cycle(1, 0, 0, 0, 16'h0000);
         if (tick === 1'b1) ticks++;
      end
      n_tests++;
      if (ticks != 4 || busy !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL periodic count: got ticks=%0d busy=%b done=%b, want 4 1 0", ticks, busy, done);
      end
      cycle(1, 0, 1, 0, 16'h0000);
   endtask

   task automatic test_oneshot();
      cur_test = "oneshot";
      cycle(1, 1, 0, MODE_ONESHOT, 16'hFFFF);
      cycle(1, 0, 0, 0, 16'h0000);
      n_tests++;
      if ({tick, busy, done} !== 3'b101) begin
         n_fail++;
         $display("FAIL oneshot first: got tick=%b busy=%b done=%b, want 1 0 1", tick, busy, done);
      end
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 16'h0000);
      cur_test = "oneshot_rearm";
      cycle(1, 1, 0, MODE_ONESHOT, 16'hFFFF);
      cycle(1, 0, 0, 0, 16'h0000);
      cycle(1, 0, 1, 0, 16'h0000);
   endtask

   task automatic test_gated();
      int ticks = 0;
      cur_test = "gated";
      cycle(1, 1, 0, MODE_PERIODIC, 16'hFFD3);
      for (int i = 0; i < 16; i++) begin
         cycle((i % 2) == 0, 0, 0, 0, 16'h0000);
         if (tick === 1'b1) begin
            ticks++;
            if ((i % 4) != 2) begin
               n_tests++; n_fail++;
               $display("FAIL gated spacing: tick at step %0d, want steps 2,6,10,14", i);
            end
         end
      end
      n_tests++;
      if (ticks != 4) begin
         n_fail++;
         $display("FAIL gated count: got %0d, want 4", ticks);
      end
      cycle(1, 0, 1, 0, 16'h0000);
   endtask

   task automatic test_cfg_err();
      cur_test = "cfg_err_idle";
      cycle(1, 1, 0, MODE_PERIODIC, 16'h0000);
      n_tests++;
      if ({cfg_err, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL cfg_err_idle: got cfg_err=%b busy=%b, want 1 0", cfg_err, busy);
      end
      cycle(1, 0, 0, 0, 16'h0000);
      cycle(1, 0, 0, 0, 16'h0000);
      cur_test = "cfg_err_done";
      cycle(1, 1, 0, MODE_ONESHOT, 16'hFFFF);
      cycle(1, 0, 0, 0, 16'h0000);
      cycle(1, 1, 0, MODE_PERIODIC, 16'h0000);
      cycle(1, 0, 0, 0, 16'h0000);
      cycle(1, 0, 1, 0, 16'h0000);
   endtask

   task automatic test_start_in_run();
      cur_test = "start_in_run";
      cycle(1, 1, 0, MODE_PERIODIC, 16'hFFD3);
      cycle(1, 0, 0, 0, 16'h0000);
      cycle(1, 1, 0, MODE_ONESHOT, 16'hFFFF);
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 16'h0000);
      n_tests++;
      if ({busy, done} !== 2'b10) begin
         n_fail++;
         $display("FAIL start_in_run state: got busy=%b done=%b, want 1 0", busy, done);
      end
      cycle(1, 0, 1, 0, 16'h0000);
   endtask

   task automatic test_stop_start();
      cur_test = "stop_start";
      cycle(1, 1, 0, MODE_PERIODIC, 16'hFFD3);
      cycle(1, 0, 0, 0, 16'h0000);
      cycle(1, 1, 1, MODE_PERIODIC, 16'hFFFF);
      n_tests++;
      if ({tick, busy, done, cfg_err} !== 4'b0000) begin
         n_fail++;
         $display("FAIL stop_start: got %b%b%b%b, want 0000", tick, busy, done, cfg_err);
      end
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 16'h0000);
   endtask

   task automatic test_async_reset();
      cur_test = "async_reset";
      cycle(1, 1, 0, MODE_PERIODIC, 16'hFFD3);
      cycle(1, 0, 0, 0, 16'h0000);
      cycle(1, 0, 0, 0, 16'h0000);
      rst = 1'b1;
      #1;
      n_tests++;
      if ({tick, busy, done, cfg_err} !== 4'b0000) begin
         n_fail++;
         $display("FAIL async_reset immediate: got %b%b%b%b, want 0000", tick, busy, done, cfg_err);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      cur_test = "after_reset";
      cycle(1, 1, 0, MODE_PERIODIC, 16'hFFD3);
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 16'h0000);
      cycle(1, 0, 1, 0, 16'h0000);
   endtask

`ifdef LFSR_TICK_COUNT_EN
   task automatic test_count();
      logic [1:0] want [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      cur_test = "count";
      cycle(1, 1, 0, MODE_PERIODIC, 16'hFFFF);
      for (int i = 0; i < 4; i++) begin
         cycle(1, 0, 0, 0, 16'h0000);
         n_tests++;
         if (tick_cnt !== want[i]) begin
            n_fail++;
            $display("FAIL count seq[%0d]: got %0d, want %0d", i, tick_cnt, want[i]);
         end
      end
      cycle(1, 0, 1, 0, 16'h0000);
   endtask
`endif

   // Legacy 1 ms term: period derived by walking the step function from SEED.
   task automatic test_legacy();
      int k = 0;
      int periods, limit, exp_c;
      int tq[$];
      cur_test = "legacy";
      p_in = SEED;
      while (p_in !== 16'hDB6C && k < 65536) begin
         #1;
         p_in = p_out;
         k++;
      end
      @(posedge clk); #1;
      if (k >= 65536) begin
         n_tests++; n_fail++;
         $display("FAIL legacy orbit: DB6C not reached from SEED");
         return;
      end
      periods = ((k + 1) * 3 <= 60000) ? 3 : 1;
      for (int n = 1; n <= periods; n++) tq.push_back(n * (k + 1));
      limit = periods * (k + 1) + 4;
      enable = 1'b1; mode = MODE_PERIODIC; term_val = 16'hDB6C; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; term_val = '0;
      for (int c = 1; c <= limit; c++) begin
         @(posedge clk); #1;
         if (tick === 1'b1) begin
            n_tests++;
            if (tq.size() == 0) begin
               n_fail++;
               $display("FAIL legacy extra tick at cycle %0d", c);
            end else begin
               exp_c = tq.pop_front();
               if (c != exp_c) begin
                  n_fail++;
                  $display("FAIL legacy spacing: tick at cycle %0d, want %0d", c, exp_c);
               end
            end
         end
      end
      while (tq.size() > 0) begin
         exp_c = tq.pop_front();
         n_tests++; n_fail++;
         $display("FAIL legacy missing tick: expected at cycle %0d", exp_c);
      end
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0; enable = 1'b0;
      model_reset();
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_oneshot();
      test_gated();
      test_cfg_err();
      test_start_in_run();
      test_stop_start();
      test_async_reset();
`ifdef LFSR_TICK_COUNT_EN
      test_count();
`endif
      test_legacy();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lfsr_tick_timer.md
Name: lfsr_tick_timer

Overview:
Parametrised, programmable LFSR-based tick generator. It is the successor to the fixed 16-bit one-millisecond tick block, with a configurable LFSR width, tap mask and seed, a runtime terminal value, and periodic or one-shot modes with start/stop control. The game timer and any other module needing a cheap long-period strobe instantiate it. It sits between the game control FSM (start/stop/mode) and the timekeeping counters (tick consumers).

Parameters:
WIDTH, 16, LFSR width in bits (4..32).
TAPS, 16'h002D, Galois tap mask; bit i set means next[i] = lfsr[i-1] ^ lfsr[WIDTH-1], and bit 0 always receives lfsr[WIDTH-1].
SEED, all ones, LFSR reload value; must be nonzero.
CNT_W, 16, tick counter width (optional feature only).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  advance qualifier; LFSR steps only when high
start  in  1  one-cycle arm pulse; samples term_val and mode
stop  in  1  one-cycle abort pulse
mode  in  1  0 = periodic, 1 = one-shot
term_val  in  WIDTH  terminal LFSR value
tick  out  1  one-cycle strobe on terminal match
busy  out  1  high in RUN
done  out  1  high in DONE (one-shot complete)
cfg_err  out  1  one-cycle pulse when start is rejected
tick_cnt  out  CNT_W  ticks since start (LFSR_TICK_COUNT_EN only)

Behaviour:
- Reset (async, rst=1): state=IDLE, lfsr=SEED, term_q=0, mode_q=0, and tick, busy, done, cfg_err, tick_cnt all 0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: lfsr is held at SEED.
  - start with term_val!=0: term_q<=term_val, mode_q<=mode, go to RUN.
  - start with term_val==0: the all-zero state is unreachable, so stay in IDLE and pulse cfg_err for 1 cycle.
- RUN, enable=1:
  - If lfsr==term_q: tick<=1 next cycle and lfsr<=SEED. If mode_q=1, go to DONE; otherwise stay in RUN.
  - Else: lfsr<=Galois next and tick<=0.
- RUN, enable=0: lfsr, state and the compare are frozen; tick<=0.
- Period: k+1 enabled cycles, where k is the number of steps from SEED to term_q. term_q==SEED gives tick on every enabled cycle. A term_q not on the SEED orbit never ticks; this is a documented hazard, not detected.
- DONE: done=1 and lfsr=SEED. start re-arms to RUN with the same rules as IDLE, including cfg_err.
- stop in any state: go to IDLE, lfsr<=SEED, tick<=0 and done<=0 on the next cycle.
- stop and start in the same cycle: stop wins and start is ignored.
- start while in RUN: ignored; term_q and mode_q are unchanged.
- term_val and mode are sampled only on an accepted start.
- A reset assertion mid-count forces reset values immediately.
- Legacy equivalence: WIDTH=16, TAPS=16'h002D, SEED=16'hFFFF, term 16'hDB6C in periodic mode reproduces the old 1 ms tick sequence.

Optional Feature:
LFSR_TICK_COUNT_EN:
- Defined: tick_cnt increments on every tick, wraps at 2^CNT_W-1 to 0, and clears on an accepted start, on stop, and on reset.
- Undefined: the tick_cnt port and its counter are absent.

Decomposition:
- Package lfsr_timer_pkg holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - MODE_PERIODIC=0 and MODE_ONESHOT=1;
  - the default 16-bit TAPS and SEED constants.
- One sub-module, lfsr_galois_step: purely combinational next-state from (lfsr, TAPS), parametrised by WIDTH. It is reused by the bench reference model.

Test Plan:
- Reset then start, term=16'hFFD3 (=next(FFFF)), periodic, enable=1 -> tick every 2nd cycle, busy=1, done=0.
- term=16'hFFFF one-shot -> single tick on the 1st enabled cycle after start, then done=1, busy=0, lfsr=FFFF; a second start re-arms.
- term=16'hFFD3 periodic, enable toggled 1/0 each cycle -> tick every 4 clocks, no tick while enable=0.
- start with term_val=0 -> cfg_err one-cycle pulse, state stays IDLE, no tick.
- stop and start in the same cycle during RUN, and async rst mid-count -> IDLE, lfsr=SEED, all outputs 0 immediately on rst.
- Legacy term 16'hDB6C periodic vs lfsr_galois_step model for 3 periods -> identical tick spacing. With LFSR_TICK_COUNT_EN and CNT_W=2, tick_cnt reads 1,2,3,0.
